// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: state encodings, stream framing constants, state helpers.
`ifndef LOADER_DEFS_SVH
`define LOADER_DEFS_SVH
`define LDR_ST_IDLE 3'd0
`define LDR_ST_LEN0 3'd1
`define LDR_ST_LEN1 3'd2
`define LDR_ST_DATA 3'd3
`define LDR_ST_CHK  3'd4
`define LDR_ST_DONE 3'd5
`define LDR_ST_ERR  3'd6
`define LDR_LEN_BYTES 2
`define LDR_BYTES_PER_WORD 4
`endif

package imem_loader_pkg;

  localparam int BYTES_PER_WORD = `LDR_BYTES_PER_WORD;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE = `LDR_ST_IDLE,
    ST_LEN0 = `LDR_ST_LEN0,
    ST_LEN1 = `LDR_ST_LEN1,
    ST_DATA = `LDR_ST_DATA,
    ST_CHK  = `LDR_ST_CHK,
    ST_DONE = `LDR_ST_DONE,
    ST_ERR  = `LDR_ST_ERR
  } state_e;

  // States in which the loader owns the byte stream.
  function automatic logic is_rx_state(input state_e s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes into little-endian 32-bit words; word_vld is combinational on the 4th byte.
// Synchronous clear drops any partial word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  localparam logic [BCNT_W-1:0] BCNT_ONE  = 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES_PER_WORD - 1);

  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]       sh_q, sh_d;

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (byte_vld) begin
      cnt_d = cnt_q + BCNT_ONE;
      sh_d  = {byte_dat, sh_q[23:8]};
    end
  end

  assign word_vld = byte_vld && (cnt_q == BCNT_LAST);
  assign word_dat = {byte_dat, sh_q};

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: LEN0,LEN1 word count then 4*N bytes into imem; holds cpu_reset until the image commits.
// Optional trailing XOR checksum word when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [31:0]     CAP      = 32'(1) << ADDR_W;
  localparam logic [ADDR_W:0] WCNT_ONE = 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER_DATA = ST_CHK;
`else
  localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       xor_q, xor_d;
`endif

  logic        xfer;
  logic        pk_clear;
  logic        pk_vld;
  logic        word_vld;
  logic [31:0] word_dat;
  logic        last_word;

  assign xfer      = in_valid && in_ready_q;
  assign pk_vld    = xfer && ((state_q == ST_DATA) || (state_q == ST_CHK));
  assign last_word = (32'(wcnt_q) + 32'd1) == {16'd0, len_q};

  imem_loader_byte_packer u_packer (
    .clk      (CLK),
    .clr      (Reset || pk_clear),
    .byte_vld (pk_vld),
    .byte_dat (in_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    wcnt_d       = wcnt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    pk_clear     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d        = xor_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d  = ST_LEN0;
          pk_clear = 1'b1;
          wcnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d    = '0;
`endif
        end
      end
      ST_LEN0: begin
        if (xfer) begin
          len_lo_d = in_data;
          state_d  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (xfer) begin
          len_d = {in_data, len_lo_q};
          if ({16'd0, len_d} > CAP)   state_d = ST_ERR;
          else if (len_d == 16'd0)    state_d = ST_AFTER_DATA;
          else                        state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_vld) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = wcnt_q[ADDR_W-1:0];
          imem_wdata_d = word_dat;
          wcnt_d       = wcnt_q + WCNT_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d        = xor_q ^ word_dat;
`endif
          if (last_word) state_d = ST_AFTER_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (word_vld) state_d = (word_dat == xor_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = is_rx_state(state_d);
    busy_d      = is_rx_state(state_d);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERR);
    // Release one cycle after entering DONE so the final write has already landed.
    cpu_reset_d = !((state_q == ST_DONE) && (state_d == ST_DONE));
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      wcnt_q       <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      wcnt_q       <= wcnt_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader with a small (4-word) memory.
// Expected writes come from a stream-level model; a negedge monitor pops them on every imem_we.
module tb_imem_loader;

  localparam int AW  = 2;
  localparam int CAP = 1 << AW;

  logic          CLK = 1'b0;
  logic          Reset, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, imem_we, cpu_reset, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0]    stim_q[$];
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_e;

  imem_loader #(.ADDR_W(AW)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge CLK) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%h expected=none t=%0t", imem_addr, imem_wdata, $time);
      end else begin
        exp_e = exp_q.pop_front();
        chk("wr_addr", 64'(imem_addr), 64'(exp_e[AW+31:32]));
        chk("wr_data", 64'(imem_wdata), 64'(exp_e[31:0]));
      end
    end
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog expired actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stim_q.push_back(w[8*i +: 8]);
  endtask

  // Appends the XOR checksum word when the checksum build is selected.
  task automatic push_tail(input bit corrupt);
`ifdef IMEM_LOADER_CHECKSUM_EN
    int n;
    logic [31:0] x;
    n = int'({stim_q[1], stim_q[0]});
    x = '0;
    for (int k = 0; k < n; k++)
      x ^= {stim_q[2+4*k+3], stim_q[2+4*k+2], stim_q[2+4*k+1], stim_q[2+4*k]};
    if (corrupt) x ^= 32'h1 << $urandom_range(0, 31);
    push_word(x);
`else
    if (corrupt) stim_q.push_back(8'h00);
`endif
  endtask

  task automatic do_start();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    int budget;
    repeat (gap) @(negedge CLK);
    @(negedge CLK);
    in_valid = 1'b1; in_data = b; start = with_start;
    budget = 0;
    while (in_ready !== 1'b1 && budget < 100) begin
      @(negedge CLK);
      budget++;
    end
    if (budget >= 100) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0; start = 1'b0;
  endtask

  // Model: derives outcome and write list from the framed stream, then drives it.
  task automatic run_load(input string name, input int max_gap, input int start_idx);
    int n, nsend;
    bit exp_ok;
    logic [31:0] w, x, c;
    n = int'({stim_q[1], stim_q[0]});
    if (n > CAP) begin
      exp_ok = 1'b0;
      nsend  = 2;
    end else begin
      x = '0;
      for (int k = 0; k < n; k++) begin
        w = {stim_q[2+4*k+3], stim_q[2+4*k+2], stim_q[2+4*k+1], stim_q[2+4*k]};
        exp_q.push_back({k[AW-1:0], w});
        x ^= w;
      end
      exp_ok = 1'b1;
      nsend  = 2 + 4*n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      c = {stim_q[nsend+3], stim_q[nsend+2], stim_q[nsend+1], stim_q[nsend]};
      exp_ok = (c == x);
      nsend += 4;
`else
      c = x;
`endif
    end
    do_start();
    for (int i = 0; i < nsend; i++)
      send_byte(stim_q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, i == start_idx);
    if (exp_ok) begin
      chk({name, "_done"}, 64'(done), 64'd1);
      chk({name, "_cpurst_hold"}, 64'(cpu_reset), 64'd1);
      chk({name, "_busy"}, 64'(busy), 64'd0);
    end else begin
      chk({name, "_error"}, 64'(error), 64'd1);
      chk({name, "_done0"}, 64'(done), 64'd0);
    end
    @(posedge CLK); #1;
    chk({name, "_cpurst_next"}, 64'(cpu_reset), exp_ok ? 64'd0 : 64'd1);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    Reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    Reset = 1'b0;

    // Two-word image, back-to-back bytes.
    stim_q.delete();
    stim_q.push_back(8'h02); stim_q.push_back(8'h00);
    push_word(32'h44332211); push_word(32'hDDCCBBAA); push_tail(1'b0);
    run_load("t1", 0, -1);

    // Empty image.
    stim_q.delete();
    stim_q.push_back(8'h00); stim_q.push_back(8'h00); push_tail(1'b0);
    run_load("t2_n0", 0, -1);

    // Just over capacity, then exactly capacity.
    stim_q.delete();
    stim_q.push_back(8'(CAP + 1)); stim_q.push_back(8'h00);
    run_load("t3_over", 0, -1);
    repeat (3) @(posedge CLK);
    #1;
    chk("t3_over_cpurst_stays", 64'(cpu_reset), 64'd1);
    stim_q.delete();
    stim_q.push_back(8'(CAP)); stim_q.push_back(8'h00);
    for (int k = 0; k < CAP; k++) push_word($urandom);
    push_tail(1'b0);
    run_load("t3_full", 0, -1);

    // Test-1 data with stalls and an ignored start pulse mid-load.
    stim_q.delete();
    stim_q.push_back(8'h02); stim_q.push_back(8'h00);
    push_word(32'h44332211); push_word(32'hDDCCBBAA); push_tail(1'b0);
    run_load("t4_gaps", 3, 5);

    // Reset after six data bytes: one word written, partial word discarded.
    do_start();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    exp_q.push_back({{AW{1'b0}}, 32'h04030201});
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 0, 1'b0);
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("t5_in_ready", 64'(in_ready), 64'd0);
    chk("t5_pending", 64'(exp_q.size()), 64'd0);
    stim_q.delete();
    stim_q.push_back(8'h01); stim_q.push_back(8'h00);
    push_word(32'hCAFEF00D); push_tail(1'b0);
    run_load("t5_restart", 0, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum must abort and keep the processor in reset.
    stim_q.delete();
    stim_q.push_back(8'h02); stim_q.push_back(8'h00);
    push_word(32'h44332211); push_word(32'hDDCCBBAA); push_tail(1'b1);
    run_load("t6_badck", 0, -1);
`endif

    // Randomized images, including oversize lengths and (checksum build) corrupted sums.
    for (int t = 0; t < 10; t++) begin
      stim_q.delete();
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(CAP + 1, 65535)) : int'($urandom_range(0, CAP));
      stim_q.push_back(n[7:0]); stim_q.push_back(n[15:8]);
      if (n <= CAP) begin
        for (int k = 0; k < n; k++) push_word($urandom);
        push_tail($urandom_range(0, 2) == 0);
      end
      run_load("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
